// File: rtl/high_score_tracker_if.sv
// Signal bundle between the game controller and the high-score tracker.
// The master side drives game status and score; the slave side returns the display value and flags.
interface high_score_tracker_if #(
  parameter int SCORE_W = 16
);
  logic               tick_10khz_i;
  logic [1:0]         mode_i;
  logic [1:0]         game_state_i;
  logic [SCORE_W-1:0] score_i;
  logic               clear_i;
  logic [SCORE_W-1:0] display_value_o;
  logic               blank_o;
  logic               new_record_o;

  modport master (
    output tick_10khz_i, mode_i, game_state_i, score_i, clear_i,
    input  display_value_o, blank_o, new_record_o
  );

  modport slave (
    input  tick_10khz_i, mode_i, game_state_i, score_i, clear_i,
    output display_value_o, blank_o, new_record_o
  );
endinterface

// File: rtl/high_score_tracker.sv
// Per-mode best-score keeper that also chooses the SSD value.
// A new record triggers a blank/unblank celebration paced by the 10 kHz tick.
module high_score_tracker #(
  parameter int SCORE_W     = 16,
  parameter int SAT_MAX     = 9999,
  parameter int FLASH_TICKS = 5000,
  parameter int FLASH_COUNT = 6
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  high_score_tracker_if.slave  bus
);
  localparam int TICK_W   = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int TOGGLE_W = $clog2(FLASH_COUNT + 1);
  localparam logic [SCORE_W-1:0]  SAT_VAL     = SCORE_W'(SAT_MAX);
  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(FLASH_TICKS - 1);
  localparam logic [TOGGLE_W-1:0] TOGGLE_LAST = TOGGLE_W'(FLASH_COUNT - 1);

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b10;
  localparam logic [1:0] GS_OVER = 2'b11;

  typedef enum logic [2:0] {IDLE, PLAY, COMPARE, CELEBRATE, HOLD} state_t;

  state_t              state_reg;
  logic [SCORE_W-1:0]  hs_reg [0:3];   // entry 0 (no mode) is never written
  logic [1:0]          mode_lat_reg;
  logic [SCORE_W-1:0]  sc_lat_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [TOGGLE_W-1:0] toggle_cnt_reg;
  logic [SCORE_W-1:0]  display_reg;
  logic                blank_reg;
  logic                new_record_reg;
  logic [SCORE_W-1:0]  sc;

  assign sc = (bus.score_i > SAT_VAL) ? SAT_VAL : bus.score_i;

  assign bus.display_value_o = display_reg;
  assign bus.blank_o         = blank_reg;
  assign bus.new_record_o    = new_record_reg;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      for (int i = 0; i < 4; i++) hs_reg[i] <= '0;
      mode_lat_reg   <= 2'b00;
      sc_lat_reg     <= '0;
      tick_cnt_reg   <= '0;
      toggle_cnt_reg <= '0;
      display_reg    <= '0;
      blank_reg      <= 1'b0;
      new_record_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          display_reg    <= bus.clear_i ? '0 : hs_reg[bus.mode_i];
          blank_reg      <= (bus.mode_i == 2'b00);
          new_record_reg <= 1'b0;
          if (bus.clear_i) begin
            for (int i = 0; i < 4; i++) hs_reg[i] <= '0;
          end
          if (bus.game_state_i == GS_PLAY) begin
            mode_lat_reg <= bus.mode_i;
            state_reg    <= PLAY;
          end
        end

        PLAY: begin
          display_reg <= sc;
          blank_reg   <= 1'b0;
          if (bus.game_state_i == GS_OVER) begin
            state_reg <= COMPARE;
          end else if (bus.game_state_i == GS_IDLE) begin
            state_reg <= IDLE;
          end
        end

        COMPARE: begin
          sc_lat_reg  <= sc;
          display_reg <= sc;
          blank_reg   <= 1'b0;
          // Strictly greater: matching the record does not count as beating it.
          if (mode_lat_reg != 2'b00 && sc > hs_reg[mode_lat_reg]) begin
            hs_reg[mode_lat_reg] <= sc;
            new_record_reg       <= 1'b1;
            tick_cnt_reg         <= '0;
            toggle_cnt_reg       <= '0;
            state_reg            <= CELEBRATE;
          end else begin
            new_record_reg <= 1'b0;
            state_reg      <= HOLD;
          end
        end

        CELEBRATE: begin
          display_reg <= sc_lat_reg;
          if (bus.game_state_i == GS_IDLE) begin
            blank_reg      <= 1'b0;
            new_record_reg <= 1'b0;
            state_reg      <= IDLE;
          end else if (bus.tick_10khz_i) begin
            if (tick_cnt_reg == TICK_LAST) begin
              tick_cnt_reg   <= '0;
              toggle_cnt_reg <= toggle_cnt_reg + 1'b1;
              if (toggle_cnt_reg == TOGGLE_LAST) begin
                blank_reg <= 1'b0;
                state_reg <= HOLD;
              end else begin
                blank_reg <= ~blank_reg;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        HOLD: begin
          display_reg <= sc_lat_reg;
          blank_reg   <= 1'b0;
          if (bus.game_state_i == GS_IDLE) begin
            new_record_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_high_score_tracker.sv
// Directed plus randomized bench for high_score_tracker against a per-mode record model.
// Inputs change 1 time unit after the rising edge; outputs are read at that same point.
module tb_high_score_tracker;
  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  high_score_tracker_if #(.SCORE_W(16)) bus ();

  high_score_tracker #(
    .SCORE_W(16), .SAT_MAX(9999), .FLASH_TICKS(5000), .FLASH_COUNT(6)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int hs_m [4];

  function automatic int sat(int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_check(int mode);
    bus.mode_i = 2'(mode);
    bus.game_state_i = 2'b00;
    step(2);
    chk("idle_display", bus.display_value_o, hs_m[mode]);
    chk("idle_blank", bus.blank_o, (mode == 0) ? 1 : 0);
    chk("idle_new_record", bus.new_record_o, 0);
    $display("idle mode=%0d display=%0d blank=%0d", mode, bus.display_value_o, bus.blank_o);
  endtask

  task automatic idle_check_all();
    for (int m = 1; m < 4; m++) idle_check(m);
  endtask

  // Runs a game; on a record it celebrates for cel_cycles ticks then aborts, else it stops in HOLD.
  task automatic play_game(int mode, int score, bit abort_play, int cel_cycles);
    bit exp_rec;
    bus.mode_i = 2'(mode);
    bus.score_i = 16'd0;
    bus.game_state_i = 2'b10;
    step(1);
    bus.score_i = 16'(score);
    step(1);
    chk("play_display", bus.display_value_o, sat(score));
    chk("play_blank", bus.blank_o, 0);
    bus.mode_i = 2'($urandom_range(0, 3));
    if (abort_play) begin
      $display("game mode=%0d score=%0d aborted in play", mode, score);
      return;
    end
    exp_rec = (mode != 0) && (sat(score) > hs_m[mode]);
    bus.game_state_i = 2'b11;
    step(2);
    chk("cmp_new_record", bus.new_record_o, exp_rec);
    chk("cmp_display", bus.display_value_o, sat(score));
    if (exp_rec) begin
      hs_m[mode] = sat(score);
      bus.tick_10khz_i = 1'b1;
      step(cel_cycles);
      chk("cel_display", bus.display_value_o, sat(score));
      chk("cel_blank_early", bus.blank_o, 0);
      bus.game_state_i = 2'b00;
      step(1);
      chk("cel_abort_blank", bus.blank_o, 0);
      bus.tick_10khz_i = 1'b0;
    end else begin
      step(1);
      chk("hold_blank", bus.blank_o, 0);
      chk("hold_new_record", bus.new_record_o, 0);
      chk("hold_display", bus.display_value_o, sat(score));
    end
    $display("game mode=%0d score=%0d record=%0d new_record=%0d", mode, score, exp_rec, bus.new_record_o);
  endtask

  initial begin
    int tq[$];
    logic prev_blank;
    int mode;
    int score;

    bus.tick_10khz_i = 1'b0;
    bus.mode_i = 2'b10;
    bus.game_state_i = 2'b00;
    bus.score_i = '0;
    bus.clear_i = 1'b0;
    for (int i = 0; i < 4; i++) hs_m[i] = 0;

    // T1: reset values, then blanking with no mode selected
    step(2);
    chk("reset_display", bus.display_value_o, 0);
    chk("reset_blank", bus.blank_o, 0);
    chk("reset_new_record", bus.new_record_o, 0);
    reset_i = 1'b0;
    step(1);
    chk("t1_display", bus.display_value_o, 0);
    chk("t1_blank", bus.blank_o, 0);
    bus.mode_i = 2'b00;
    step(1);
    chk("t1_blank_mode0", bus.blank_o, 1);
    $display("t1 reset display=%0d blank=%0d", bus.display_value_o, bus.blank_o);

    // T2: full celebration for a mode-10 record of 42
    bus.mode_i = 2'b10;
    bus.game_state_i = 2'b10;
    step(1);
    bus.score_i = 16'd42;
    step(1);
    chk("t2_play_display", bus.display_value_o, 42);
    bus.game_state_i = 2'b11;
    step(2);
    chk("t2_new_record", bus.new_record_o, 1);
    hs_m[2] = 42;
    bus.tick_10khz_i = 1'b1;
    prev_blank = bus.blank_o;
    for (int i = 1; i <= 31000; i++) begin
      step(1);
      if (bus.blank_o !== prev_blank) begin
        tq.push_back(i);
        prev_blank = bus.blank_o;
      end
    end
    bus.tick_10khz_i = 1'b0;
    chk("t2_toggle_count", tq.size(), 6);
    for (int k = 0; k < tq.size(); k++) chk("t2_toggle_time", tq[k], 5000 * (k + 1));
    chk("t2_end_blank", bus.blank_o, 0);
    chk("t2_hold_new_record", bus.new_record_o, 1);
    chk("t2_hold_display", bus.display_value_o, 42);
    $display("t2 celebration toggles=%0d", tq.size());
    bus.game_state_i = 2'b00;
    step(1);
    chk("t2_exit_new_record", bus.new_record_o, 0);
    idle_check(2);

    // T3: tie is not a record
    play_game(2, 42, 0, 0);
    idle_check(2);

    // T4: saturation in mode 11
    play_game(3, 12000, 0, 10);
    idle_check(3);

    // game_state 11 seen in IDLE must be ignored
    bus.game_state_i = 2'b11;
    step(3);
    chk("idle_ignore_over", bus.display_value_o, hs_m[bus.mode_i]);
    idle_check(3);

    // T5: record then abort mid-celebration; clear in HOLD ignored, clear in IDLE honoured
    play_game(1, 777, 0, 1234);
    idle_check_all();
    play_game(1, 5, 0, 0);
    bus.clear_i = 1'b1;
    step(2);
    bus.clear_i = 1'b0;
    idle_check_all();
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
    for (int i = 0; i < 4; i++) hs_m[i] = 0;
    idle_check_all();

    // Randomized games against the record model
    for (int g = 0; g < 30; g++) begin
      mode = $urandom_range(0, 3);
      score = ($urandom_range(0, 3) == 0) ? hs_m[mode] : $urandom_range(0, 12000);
      play_game(mode, score, ($urandom_range(0, 4) == 0), $urandom_range(1, 300));
      idle_check(mode);
      if (g % 5 == 4) idle_check_all();
    end

    // T6: reset mid-PLAY
    bus.mode_i = 2'b01;
    bus.game_state_i = 2'b10;
    step(1);
    bus.score_i = 16'd500;
    step(1);
    reset_i = 1'b1;
    bus.game_state_i = 2'b00;
    step(1);
    chk("t6_display", bus.display_value_o, 0);
    chk("t6_blank", bus.blank_o, 0);
    chk("t6_new_record", bus.new_record_o, 0);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) hs_m[i] = 0;
    idle_check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
